// File: rtl/lock_pkg.sv
// Shared definitions for the shared-device lock.
//   LOCK_ACQUIRE / LOCK_RELEASE : data values written to the lock register
//   arb_mode_e                  : arbitration policy selector
//   lock_state_e                : FREE / OWNED lock state
//   owner_idx_w()               : width of an owner index that can also encode "free"
package lock_pkg;

  localparam logic [31:0] LOCK_ACQUIRE = 32'd1;
  localparam logic [31:0] LOCK_RELEASE = 32'd0;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

  typedef enum logic {ST_FREE = 1'b0, ST_OWNED = 1'b1} lock_state_e;

  // Index range is 0..n, where the value n means "no owner".
  function automatic int owner_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_arbiter.sv
// Combinational N-way request picker.
//   i_req    : per-client request vector
//   i_rr_ptr : round-robin start index (ignored in fixed mode)
//   o_win    : winning client index
//   o_vld    : at least one request present
module lock_arbiter
  import lock_pkg::*;
#(
  parameter int        N    = 2,
  parameter arb_mode_e MODE = ARB_FIXED,
  localparam int       W    = owner_idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_rr_ptr,
  output logic [W-1:0] o_win,
  output logic         o_vld
);

  always_comb begin
    int v_best;
    int v_dist;
    o_win  = '0;
    o_vld  = |i_req;
    v_best = N;
    v_dist = 0;
    if (MODE == ARB_FIXED) begin
      // Descending scan so the lowest requesting index is written last.
      for (int j = N - 1; j >= 0; j--) begin
        if (i_req[j]) o_win = W'(j);
      end
    end else begin
      // Pick the requester with the smallest modular distance from the pointer.
      for (int j = 0; j < N; j++) begin
        v_dist = (j - int'(i_rr_ptr) + N) % N;
        if (i_req[j] && (v_dist < v_best)) begin
          v_best = v_dist;
          o_win  = W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/shared_dev_lock.sv
// Lock/arbiter letting N_CLIENTS cores share one memory-mapped accelerator.
// A core writes 1 to LOCK_ADDR to acquire and 0 to release; only the owner's
// bus traffic is forwarded. An inactivity watchdog force-releases a stalled owner.
//   clk, rst        : clock, asynchronous active-high reset
//   addr_in/wr_en_in/select_in/data_in : per-core bus ports
//   data_accel_in   : accelerator read data
//   addr_o/wr_en_o/accel_select_o      : forwarded owner traffic
//   data_out        : per-core read data (lock register or accelerator)
//   lock_owner_o    : owner index, N_CLIENTS when free
//   lock_busy_o     : lock held
//   timeout_o       : one-cycle pulse on watchdog release
module shared_dev_lock
  import lock_pkg::*;
#(
  parameter int          N_CLIENTS      = 2,
  parameter logic [31:0] LOCK_ADDR      = 32'd84,
  parameter int          ARB_MODE       = 0,
  parameter int          TIMEOUT_CYCLES = 1024,
  localparam int         OWNER_W        = owner_idx_w(N_CLIENTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CLIENTS-1:0][31:0]  addr_in,
  input  logic [N_CLIENTS-1:0]        wr_en_in,
  input  logic [N_CLIENTS-1:0]        select_in,
  input  logic [N_CLIENTS-1:0][31:0]  data_in,
  input  logic [31:0]                 data_accel_in,
  output logic [31:0]                 addr_o,
  output logic                        wr_en_o,
  output logic                        accel_select_o,
  output logic [N_CLIENTS-1:0][31:0]  data_out,
  output logic [OWNER_W-1:0]          lock_owner_o,
  output logic                        lock_busy_o,
  output logic                        timeout_o
);

  localparam int                 CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [OWNER_W-1:0] FREE_IDX = OWNER_W'(N_CLIENTS);

  lock_state_e          r_state,   w_state_nxt;
  logic [OWNER_W-1:0]   r_owner,   w_owner_nxt;
  logic [OWNER_W-1:0]   r_rr_ptr,  w_rr_nxt;
  logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
  logic                 r_timeout, w_timeout_nxt;

  logic [N_CLIENTS-1:0] w_acq, w_rel;
  logic [OWNER_W-1:0]   w_win;
  logic                 w_win_vld;
  logic                 w_own_sel, w_own_wr, w_own_rel;
  logic [31:0]          w_own_addr;

  // Lock-register write decode; other data values at LOCK_ADDR match neither.
  always_comb begin
    w_acq = '0;
    w_rel = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (select_in[i] && wr_en_in[i] && (addr_in[i] == LOCK_ADDR)) begin
        w_acq[i] = (data_in[i] == LOCK_ACQUIRE);
        w_rel[i] = (data_in[i] == LOCK_RELEASE);
      end
    end
  end

  // Owner's bus signals; all zero while free.
  always_comb begin
    w_own_sel  = 1'b0;
    w_own_wr   = 1'b0;
    w_own_rel  = 1'b0;
    w_own_addr = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if ((r_state == ST_OWNED) && (r_owner == OWNER_W'(i))) begin
        w_own_sel  = select_in[i];
        w_own_wr   = wr_en_in[i];
        w_own_rel  = w_rel[i];
        w_own_addr = addr_in[i];
      end
    end
  end

  lock_arbiter #(
    .N    (N_CLIENTS),
    .MODE (arb_mode_e'(ARB_MODE))
  ) u_arb (
    .i_req    (w_acq),
    .i_rr_ptr (r_rr_ptr),
    .o_win    (w_win),
    .o_vld    (w_win_vld)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FREE;
      r_owner   <= FREE_IDX;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_nxt      = r_rr_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_FREE: begin
        w_cnt_nxt = '0;
        if (w_win_vld) begin
          w_state_nxt = ST_OWNED;
          w_owner_nxt = w_win;
          w_rr_nxt    = (w_win == OWNER_W'(N_CLIENTS - 1)) ? '0 : w_win + OWNER_W'(1);
        end
      end
      ST_OWNED: begin
        // Release takes precedence; other clients' requests this cycle are dropped.
        if (w_own_rel) begin
          w_state_nxt = ST_FREE;
          w_owner_nxt = FREE_IDX;
          w_cnt_nxt   = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (w_own_sel) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt   = ST_FREE;
            w_owner_nxt   = FREE_IDX;
            w_cnt_nxt     = '0;
            w_timeout_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_FREE;
        w_owner_nxt = FREE_IDX;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    addr_o         = w_own_addr;
    wr_en_o        = w_own_wr;
    // Lock-register traffic is never passed to the accelerator.
    accel_select_o = w_own_sel && (w_own_addr != LOCK_ADDR);
    lock_owner_o   = r_owner;
    lock_busy_o    = (r_owner != FREE_IDX);
    timeout_o      = r_timeout;
    data_out       = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (addr_in[i] == LOCK_ADDR)
        data_out[i] = 32'(r_owner);
      else if ((r_state == ST_OWNED) && (r_owner == OWNER_W'(i)))
        data_out[i] = data_accel_in;
    end
  end

endmodule

// File: tb/tb_shared_dev_lock.sv
module tb_shared_dev_lock;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0][31:0]  addr_in, data_in;
  logic [1:0]        wr_en_in, select_in;
  logic [31:0]       accel = 32'hDEADBEEF;

  // dut0: fixed priority, watchdog 8; dut1: round-robin, watchdog disabled
  logic [31:0]      d0_addr, d1_addr;
  logic             d0_wr, d1_wr, d0_sel, d1_sel, d0_busy, d1_busy, d0_to, d1_to;
  logic [1:0][31:0] d0_dout, d1_dout;
  logic [1:0]       d0_own, d1_own;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shared_dev_lock #(.N_CLIENTS(2), .LOCK_ADDR(32'd84), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut0 (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wr_en_in(wr_en_in), .select_in(select_in),
    .data_in(data_in), .data_accel_in(accel), .addr_o(d0_addr), .wr_en_o(d0_wr),
    .accel_select_o(d0_sel), .data_out(d0_dout), .lock_owner_o(d0_own),
    .lock_busy_o(d0_busy), .timeout_o(d0_to));

  shared_dev_lock #(.N_CLIENTS(2), .LOCK_ADDR(32'd84), .ARB_MODE(1), .TIMEOUT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .addr_in(addr_in), .wr_en_in(wr_en_in), .select_in(select_in),
    .data_in(data_in), .data_accel_in(accel), .addr_o(d1_addr), .wr_en_o(d1_wr),
    .accel_select_o(d1_sel), .data_out(d1_dout), .lock_owner_o(d1_own),
    .lock_busy_o(d1_busy), .timeout_o(d1_to));

  typedef struct {
    logic [1:0]  sel, wr;
    logic [31:0] a0, a1, dat0, dat1;
    logic [1:0]  eown;
    logic        ebusy, esel, ewr;
    logic [31:0] eaddr, eo0, eo1;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] sel, input logic [1:0] wr,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] dat0, input logic [31:0] dat1);
    select_in  = sel;
    wr_en_in   = wr;
    addr_in[0] = a0;
    addr_in[1] = a1;
    data_in[0] = dat0;
    data_in[1] = dat1;
  endtask

  task automatic idle();
    set_req(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int seen_to;
    idle();
    rst = 1'b1;
    #3;
    chk("reset_owner", 32'(d0_own), 32'd2);
    chk("reset_busy", 32'(d0_busy), 32'd0);
    chk("reset_timeout", 32'(d0_to), 32'd0);
    chk("reset_sel", 32'(d0_sel), 32'd0);
    chk("reset_rr_owner", 32'(d1_own), 32'd2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // sel wr a0 a1 dat0 dat1 | own busy sel wr addr_o dout0 dout1
    vq.push_back('{2'b00, 2'b00, 32'd0,  32'd0,    32'd0, 32'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0, 32'd0});
    vq.push_back('{2'b10, 2'b10, 32'd0,  32'd84,   32'd0, 32'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0, 32'd2});
    vq.push_back('{2'b11, 2'b00, 32'd84, 32'h20,   32'd0, 32'd0, 2'd1, 1'b1, 1'b1, 1'b0, 32'h20,   32'd1, 32'hDEADBEEF});
    vq.push_back('{2'b01, 2'b00, 32'h20, 32'd0,    32'd0, 32'd0, 2'd1, 1'b1, 1'b0, 1'b0, 32'd0,    32'd0, 32'hDEADBEEF});
    vq.push_back('{2'b11, 2'b11, 32'd84, 32'h10,   32'd1, 32'd5, 2'd1, 1'b1, 1'b1, 1'b1, 32'h10,   32'd1, 32'hDEADBEEF});
    vq.push_back('{2'b11, 2'b11, 32'd84, 32'd84,   32'd0, 32'd1, 2'd1, 1'b1, 1'b0, 1'b1, 32'd84,   32'd1, 32'd1});
    vq.push_back('{2'b11, 2'b11, 32'd84, 32'd84,   32'd1, 32'd0, 2'd1, 1'b1, 1'b0, 1'b1, 32'd84,   32'd1, 32'd1});
    vq.push_back('{2'b00, 2'b00, 32'd0,  32'd0,    32'd0, 32'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0, 32'd0});
    vq.push_back('{2'b11, 2'b11, 32'd84, 32'd84,   32'd1, 32'd1, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0,    32'd2, 32'd2});
    vq.push_back('{2'b00, 2'b00, 32'd0,  32'd0,    32'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0,    32'hDEADBEEF, 32'd0});
    vq.push_back('{2'b01, 2'b01, 32'd84, 32'd0,    32'd0, 32'd0, 2'd0, 1'b1, 1'b0, 1'b1, 32'd84,   32'd0, 32'd0});
    vq.push_back('{2'b00, 2'b00, 32'd0,  32'd0,    32'd0, 32'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0, 32'd0});
    vq.push_back('{2'b01, 2'b01, 32'd84, 32'd0,    32'd2, 32'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0,    32'd2, 32'd0});
    vq.push_back('{2'b00, 2'b00, 32'd0,  32'd0,    32'd0, 32'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'd0,    32'd0, 32'd0});

    for (int k = 0; k < vq.size(); k++) begin
      set_req(vq[k].sel, vq[k].wr, vq[k].a0, vq[k].a1, vq[k].dat0, vq[k].dat1);
      #1;
      chk($sformatf("v%0d_owner", k), 32'(d0_own), 32'(vq[k].eown));
      chk($sformatf("v%0d_busy", k), 32'(d0_busy), 32'(vq[k].ebusy));
      chk($sformatf("v%0d_sel", k), 32'(d0_sel), 32'(vq[k].esel));
      chk($sformatf("v%0d_wr", k), 32'(d0_wr), 32'(vq[k].ewr));
      chk($sformatf("v%0d_addr", k), d0_addr, vq[k].eaddr);
      chk($sformatf("v%0d_dout0", k), d0_dout[0], vq[k].eo0);
      chk($sformatf("v%0d_dout1", k), d0_dout[1], vq[k].eo1);
      chk($sformatf("v%0d_timeout", k), 32'(d0_to), 32'd0);
      @(posedge clk);
      #1;
    end

    // Round-robin rotation versus fixed priority on simultaneous requests
    do_reset();
    set_req(2'b11, 2'b11, 32'd84, 32'd84, 32'd1, 32'd1);
    cyc();
    idle();
    #1;
    chk("rr_first_owner", 32'(d1_own), 32'd0);
    chk("fix_first_owner", 32'(d0_own), 32'd0);
    set_req(2'b11, 2'b11, 32'd84, 32'd84, 32'd0, 32'd0);
    cyc();
    idle();
    #1;
    chk("rr_released", 32'(d1_own), 32'd2);
    set_req(2'b11, 2'b11, 32'd84, 32'd84, 32'd1, 32'd1);
    cyc();
    idle();
    #1;
    chk("rr_second_owner", 32'(d1_own), 32'd1);
    chk("fix_second_owner", 32'(d0_own), 32'd0);
    set_req(2'b11, 2'b11, 32'd84, 32'd84, 32'd0, 32'd0);
    cyc();
    idle();
    #1;
    chk("rr_released2", 32'(d1_own), 32'd2);
    set_req(2'b11, 2'b11, 32'd84, 32'd84, 32'd1, 32'd1);
    cyc();
    idle();
    #1;
    chk("rr_wrap_owner", 32'(d1_own), 32'd0);

    // Watchdog: 8 idle owner cycles force a release with a one-cycle pulse
    do_reset();
    set_req(2'b01, 2'b01, 32'd84, 32'd0, 32'd1, 32'd0);
    cyc();
    idle();
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("wd_hold%0d_owner", k), 32'(d0_own), 32'd0);
      chk($sformatf("wd_hold%0d_to", k), 32'(d0_to), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("wd_fire_owner", 32'(d0_own), 32'd2);
    chk("wd_fire_busy", 32'(d0_busy), 32'd0);
    chk("wd_fire_to", 32'(d0_to), 32'd1);
    cyc();
    chk("wd_pulse_end", 32'(d0_to), 32'd0);
    chk("wd_no_wd_owner", 32'(d1_own), 32'd0);

    // Owner touching the bus every 7th cycle keeps the lock
    do_reset();
    set_req(2'b01, 2'b01, 32'd84, 32'd0, 32'd1, 32'd0);
    cyc();
    seen_to = 0;
    for (int c = 0; c < 30; c++) begin
      set_req({1'b0, (c % 7) == 6}, 2'b00, 32'h40, 32'd0, 32'd0, 32'd0);
      #1;
      if (d0_to) seen_to++;
      @(posedge clk);
      #1;
    end
    chk("keepalive_owner", 32'(d0_own), 32'd0);
    chk("keepalive_no_to", 32'(seen_to), 32'd0);

    // Asynchronous reset while owned; rr_ptr must also clear
    do_reset();
    set_req(2'b01, 2'b01, 32'd84, 32'd0, 32'd1, 32'd0);
    cyc();
    set_req(2'b01, 2'b01, 32'h10, 32'd0, 32'h55, 32'd0);
    #1;
    chk("pre_rst_sel", 32'(d0_sel), 32'd1);
    chk("pre_rst_addr", d0_addr, 32'h10);
    chk("pre_rst_rr_owner", 32'(d1_own), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_owner", 32'(d0_own), 32'd2);
    chk("arst_busy", 32'(d0_busy), 32'd0);
    chk("arst_sel", 32'(d0_sel), 32'd0);
    chk("arst_wr", 32'(d0_wr), 32'd0);
    chk("arst_addr", d0_addr, 32'd0);
    chk("arst_dout0", d0_dout[0], 32'd0);
    chk("arst_rr_owner", 32'(d1_own), 32'd2);
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    set_req(2'b11, 2'b11, 32'd84, 32'd84, 32'd1, 32'd1);
    cyc();
    idle();
    #1;
    chk("rr_ptr_cleared", 32'(d1_own), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
